// File: rtl/heightmap_pixel_writer_pkg.sv
// Shared types and constants for the heightmap writer and the VGA blocks.
// Holds colour thresholds, RGB332 palette and writer FSM encoding.
package heightmap_pixel_writer_pkg;

  localparam int COORD_W = 10;
  localparam int Z_W     = 8;
  localparam int DIM_W   = 9;
  localparam int ADDR_W  = 19;
  localparam int FIFO_W  = 2*COORD_W + Z_W;
  localparam int FIFO_D  = 4;

  localparam logic [Z_W-1:0] Z_SAND  = 8'd64;
  localparam logic [Z_W-1:0] Z_GRASS = 8'd96;
  localparam logic [Z_W-1:0] Z_ROCK  = 8'd160;
  localparam logic [Z_W-1:0] Z_SNOW  = 8'd224;

  localparam logic [7:0] RGB_WATER = 8'h03;
  localparam logic [7:0] RGB_SAND  = 8'hF4;
  localparam logic [7:0] RGB_GRASS = 8'h14;
  localparam logic [7:0] RGB_ROCK  = 8'h92;
  localparam logic [7:0] RGB_SNOW  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } hpw_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
  } sample_t;

endpackage

// File: rtl/heightmap_pixel_writer_fifo.sv
// sample_fifo: small synchronous FIFO between the operator and the writer.
// Depth must be a power of two; push is ignored when full.
module sample_fifo
  import heightmap_pixel_writer_pkg::*;
#(
  parameter int W = FIFO_W,
  parameter int D = FIFO_D
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(D));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/heightmap_pixel_writer.sv
// Expands heightmap samples into SCALE x SCALE RGB332 pixel blocks
// and streams them to the framebuffer write port.
module heightmap_pixel_writer
  import heightmap_pixel_writer_pkg::*;
#(
  parameter int SCALE    = 2,
  parameter int X_OFF    = 0,
  parameter int Y_OFF    = 0,
  parameter int SCREEN_W = 640
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [Z_W-1:0]     in_z,
  input  logic [DIM_W-1:0]   in_dim,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  input  logic               wr_wait,
  output logic               frame_done
);

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $error("SCALE must be in 1..4");
  end

  localparam logic [1:0] SMAX = 2'(SCALE - 1);

  hpw_state_e        state;
  sample_t           head;
  sample_t           cur;
  logic [FIFO_W-1:0] head_bits;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              run_q;
  logic              cur_last;
  logic              is_last;
  logic              last_px;
  logic [1:0]        dx;
  logic [1:0]        dy;
  logic [1:0]        nx_dx;
  logic [1:0]        nx_dy;
  logic [7:0]        colour;
  logic [COORD_W-1:0] dim_m1;
  logic [ADDR_W-1:0] base_col;
  logic [ADDR_W-1:0] base_row;
  logic [ADDR_W-1:0] load_col;
  logic [ADDR_W-1:0] load_row;

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [ADDR_W-1:0] row,
    input logic [ADDR_W-1:0] col
  );
    return row * ADDR_W'(SCREEN_W) + col;
  endfunction

  // run_q keeps in_ready low until the first edge after reset release
  assign in_ready = run_q && !fifo_full && (state != ST_DONE);
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign head     = sample_t'(head_bits);

  sample_fifo #(
    .W (FIFO_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({in_x, in_y, in_z}),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    colour = RGB_SNOW;
    unique case (1'b1)
      (cur.z < Z_SAND):                     colour = RGB_WATER;
      (cur.z >= Z_SAND  && cur.z < Z_GRASS): colour = RGB_SAND;
      (cur.z >= Z_GRASS && cur.z < Z_ROCK):  colour = RGB_GRASS;
      (cur.z >= Z_ROCK  && cur.z < Z_SNOW):  colour = RGB_ROCK;
      default:                              colour = RGB_SNOW;
    endcase
  end

  assign dim_m1   = COORD_W'(in_dim) - COORD_W'(1);
  assign is_last  = (cur.x == dim_m1) && (cur.y == dim_m1);
  assign load_col = ADDR_W'(cur.x) * ADDR_W'(SCALE) + ADDR_W'(X_OFF);
  assign load_row = ADDR_W'(cur.y) * ADDR_W'(SCALE) + ADDR_W'(Y_OFF);
  assign last_px  = (dx == SMAX) && (dy == SMAX);
  assign nx_dx    = (dx == SMAX) ? 2'd0 : dx + 2'd1;
  assign nx_dy    = (dx == SMAX) ? dy + 2'd1 : dy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      run_q      <= 1'b0;
      cur        <= '0;
      cur_last   <= 1'b0;
      base_col   <= '0;
      base_row   <= '0;
      dx         <= '0;
      dy         <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur   <= head;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          base_col <= load_col;
          base_row <= load_row;
          cur_last <= is_last;
          dx       <= '0;
          dy       <= '0;
          wr_en    <= 1'b1;
          wr_addr  <= pix_addr(load_row, load_col);
          wr_data  <= colour;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!wr_wait) begin
            dx <= nx_dx;
            dy <= last_px ? 2'd0 : nx_dy;
            if (last_px) begin
              wr_en <= 1'b0;
              if (cur_last) begin
                state      <= ST_DONE;
                frame_done <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              wr_addr <= pix_addr(base_row + ADDR_W'(nx_dy),
                                  base_col + ADDR_W'(nx_dx));
            end
          end
        end
        ST_DONE: begin
          wr_en      <= 1'b0;
          frame_done <= 1'b1;
        end
      endcase
    end
  end

endmodule
